// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: CPU/baud-side signal bundle for uart_transmitter.
// The stop2 input exists only when UART_TX_TWO_STOP_EN is defined.
interface uart_transmitter_if #(
    parameter int DATA_BITS = 8
);
    logic                 bclk;
    logic [DATA_BITS-1:0] data_in;
    logic                 write_en;
    logic                 tx_en;
    logic                 parity_en;
    logic                 parity_type;
    logic [1:0]           tx_thr_val;
`ifdef UART_TX_TWO_STOP_EN
    logic                 stop2;
`endif
    logic                 txd;
    logic                 tx_bclk_en;
    logic                 tx_busy;
    logic                 tx_ov;
    logic                 tx_thr;
    logic                 tx_empty;

    // Driver side: CPU register file plus baud generator
    modport master (
        output bclk, data_in, write_en, tx_en, parity_en, parity_type, tx_thr_val,
`ifdef UART_TX_TWO_STOP_EN
        output stop2,
`endif
        input  txd, tx_bclk_en, tx_busy, tx_ov, tx_thr, tx_empty
    );

    // Transmitter side
    modport slave (
        input  bclk, data_in, write_en, tx_en, parity_en, parity_type, tx_thr_val,
`ifdef UART_TX_TWO_STOP_EN
        input  stop2,
`endif
        output txd, tx_bclk_en, tx_busy, tx_ov, tx_thr, tx_empty
    );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: 16-entry TX FIFO feeding a start/data/parity/stop
// serialiser. Every bit spans OSR bclk ticks so frames line up with the
// 16x-oversampling receiver. Define UART_TX_TWO_STOP_EN to add the stop2
// input (two stop bits when set at frame start).
module uart_transmitter #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int OSR        = 16
) (
    input  logic              clk,
    input  logic              resetn,
    uart_transmitter_if.slave tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OSR);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wptr_q, rptr_q, level;
    logic                 fifo_empty, fifo_full, push, pop;

    // Serialiser state
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_en_q, par_en_d;
    logic                 par_val_q, par_val_d;
    logic                 txd_q, txd_d;
    logic                 ov_q, thr_q, thr_d, empty_q;
    logic                 start_ok, last, load, busy;
`ifdef UART_TX_TWO_STOP_EN
    logic                 stop2_q, stop2_d;
    logic                 stop_ph_q, stop_ph_d;
`endif

    assign level      = wptr_q - rptr_q;
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push       = tx.write_en && !fifo_full;
    assign pop        = load;
    assign start_ok   = tx.tx_en && !fifo_empty;
    assign last       = tx.bclk && (cnt_q == CW'(OSR - 1));
    assign busy       = (state_q != IDLE);

    assign tx.txd        = txd_q;
    assign tx.tx_busy    = busy;
    assign tx.tx_bclk_en = busy;
    assign tx.tx_ov      = ov_q;
    assign tx.tx_thr     = thr_q;
    assign tx.tx_empty   = empty_q;

    // FIFO data write; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= tx.data_in;
    end

    // FIFO pointers; a simultaneous push and pop both take effect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Threshold compare on the current level, registered one cycle later
    always_comb begin
        thr_d = 1'b0;
        case (tx.tx_thr_val)
            2'b00:   thr_d = (level == '0);
            2'b01:   thr_d = (level <= (AW+1)'(2));
            2'b10:   thr_d = (level <= (AW+1)'(4));
            default: thr_d = (level <= (AW+1)'(8));
        endcase
    end

    // Status flags: overflow pulse, threshold, idle-and-drained
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ov_q    <= 1'b0;
            thr_q   <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            ov_q    <= tx.write_en && fifo_full;
            thr_q   <= thr_d;
            empty_q <= fifo_empty && (state_q == IDLE);
        end
    end

    // Next state: bit timing, frame sequencing, frame load from the FIFO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_val_d = par_val_q;
        load      = 1'b0;
        txd_d     = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d   = stop2_q;
        stop_ph_d = stop_ph_q;
`endif
        // bclk is only meaningful once the baud generator is requested
        if (busy && tx.bclk) cnt_d = last ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: if (start_ok) load = 1'b1;
            START: begin
                if (last) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IW'(DATA_BITS - 1)) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (last) state_d = STOP;
            STOP: begin
                if (last) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (stop2_q && !stop_ph_q) stop_ph_d = 1'b1;
                    else if (start_ok)         load = 1'b1;
                    else                       state_d = IDLE;
`else
                    if (start_ok) load = 1'b1;
                    else          state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame load: framing options are frozen here for the whole frame
        if (load) begin
            state_d   = START;
            cnt_d     = '0;
            idx_d     = '0;
            shreg_d   = mem_q[rptr_q[AW-1:0]];
            par_en_d  = tx.parity_en;
            par_val_d = tx.parity_type ? ~^shreg_d : ^shreg_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_d   = tx.stop2;
            stop_ph_d = 1'b0;
`endif
        end

        // Line level follows the state being entered so txd is a clean flop
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            PARITY:  txd_d = par_val_d;
            default: txd_d = 1'b1;
        endcase
    end

    // Serialiser registers; reset forces the line back to idle-high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_val_q <= 1'b0;
            txd_q     <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= 1'b0;
            stop_ph_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_val_q <= par_val_d;
            txd_q     <= txd_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= stop2_d;
            stop_ph_q <= stop_ph_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: frame-level reference model checked every cycle,
// plus literal checks of frame bits, durations and status timing.
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_transmitter_if ifc ();

    uart_transmitter dut (
        .clk    (clk),
        .resetn (resetn),
        .tx     (ifc)
    );

    // Baud generator: one bclk every 4 clk while requested, phase restarts when idle
    logic [1:0] bcnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn)              bcnt <= 2'd0;
        else if (!ifc.tx_bclk_en) bcnt <= 2'd0;
        else                      bcnt <= bcnt + 2'd1;
    end
    assign ifc.bclk = ifc.tx_bclk_en && (bcnt == 2'd3);

    int n_cmp = 0;
    int n_bad = 0;
    int ov_cnt = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endfunction

    // Reference model: byte queue plus the active frame as a bit vector,
    // each bit lasting 64 clk (16 bclk x 4 clk)
    logic [7:0]  mq[$];
    bit          m_act = 1'b0;
    int          m_es = 0, m_nb = 10, cyc = 0;
    logic [10:0] m_bits = '1;
    logic        e_txd = 1'b1, e_busy = 1'b0, e_ov = 1'b0, e_thr = 1'b1, e_empty = 1'b1;

    task automatic model_step();
        int sz;
        logic [7:0] b;
        if (!resetn) begin
            mq.delete();
            m_act = 1'b0; cyc = 0;
            e_txd = 1'b1; e_busy = 1'b0; e_ov = 1'b0; e_thr = 1'b1; e_empty = 1'b1;
            return;
        end
        cyc++;
        sz = mq.size();
        e_ov = ifc.write_en && (sz == 16);
        case (ifc.tx_thr_val)
            2'b00:   e_thr = (sz == 0);
            2'b01:   e_thr = (sz <= 2);
            2'b10:   e_thr = (sz <= 4);
            default: e_thr = (sz <= 8);
        endcase
        e_empty = (sz == 0) && !m_act;
        if (m_act && cyc == m_es + 64 * m_nb) m_act = 1'b0;
        if (!m_act && ifc.tx_en && sz > 0) begin
            b = mq.pop_front();
            m_bits = '1;
            m_bits[0] = 1'b0;
            m_bits[8:1] = b;
            if (ifc.parity_en) begin
                m_bits[9] = ifc.parity_type ? ~^b : ^b;
                m_nb = 11;
            end else begin
                m_nb = 10;
            end
            m_act = 1'b1;
            m_es = cyc;
        end
        if (ifc.write_en && sz < 16) mq.push_back(ifc.data_in);
        e_busy = m_act;
        e_txd = m_act ? m_bits[(cyc - m_es) / 64] : 1'b1;
    endtask

    initial forever begin
        @(posedge clk or negedge resetn);
        model_step();
    end

    // Compare every cycle, 1 ns after the active edge
    initial forever begin
        @(posedge clk);
        #1;
        chk("txd",        ifc.txd,        e_txd);
        chk("tx_busy",    ifc.tx_busy,    e_busy);
        chk("tx_bclk_en", ifc.tx_bclk_en, e_busy);
        chk("tx_ov",      ifc.tx_ov,      e_ov);
        chk("tx_thr",     ifc.tx_thr,     e_thr);
        chk("tx_empty",   ifc.tx_empty,   e_empty);
        if (ifc.tx_ov === 1'b1) ov_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic put_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ifc.write_en = 1'b1;
            ifc.data_in  = first + 8'(i);
        end
        @(negedge clk);
        ifc.write_en = 1'b0;
    endtask

    // Wait for busy to rise, then sample each bit mid-way and measure busy width
    task automatic frame_cap(input int nb, output logic [10:0] bits, output int width);
        bit seen = 1'b0;
        bits = '1;
        width = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk); #1;
            if (ifc.tx_busy === 1'b1) seen = 1'b1;
        end
        chk("busy_rise", {31'd0, seen}, 32'd1);
        if (seen) begin
            for (int t = 1; t <= 20000; t++) begin
                @(posedge clk); #1;
                if (t % 64 == 32 && t / 64 < nb) bits[t / 64] = ifc.txd;
                if (ifc.tx_busy !== 1'b1) begin
                    width = t;
                    break;
                end
            end
        end
    endtask

    logic [10:0] bits;
    int w, t_cnt, thr_rise, busy_cyc;

    initial begin
        ifc.data_in = '0; ifc.write_en = 1'b0; ifc.tx_en = 1'b0;
        ifc.parity_en = 1'b0; ifc.parity_type = 1'b0; ifc.tx_thr_val = 2'b00;
`ifdef UART_TX_TWO_STOP_EN
        ifc.stop2 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_txd",   ifc.txd,        1);
        chk("rst_bclk",  ifc.tx_bclk_en, 0);
        chk("rst_busy",  ifc.tx_busy,    0);
        chk("rst_ov",    ifc.tx_ov,      0);
        chk("rst_thr",   ifc.tx_thr,     1);
        chk("rst_empty", ifc.tx_empty,   1);
        resetn = 1'b1;

        // 0xA5, no parity: 10 bits of 64 clk
        @(negedge clk); ifc.tx_en = 1'b1;
        fork put_seq(8'hA5, 1); frame_cap(10, bits, w); join
        chk("A5_bits",  bits[9:0], 10'b1_10100101_0);
        chk("A5_width", w, 640);

        // 0x07 with even-type parity (bit 1), then odd-type (bit 0)
        ifc.parity_en = 1'b1; ifc.parity_type = 1'b0;
        fork put_seq(8'h07, 1); frame_cap(11, bits, w); join
        chk("p0_bits",  bits, 11'b1_1_00000111_0);
        chk("p0_par",   bits[9], 1);
        chk("p0_width", w, 704);
        ifc.parity_type = 1'b1;
        fork put_seq(8'h07, 1); frame_cap(11, bits, w); join
        chk("p1_bits",  bits, 11'b1_0_00000111_0);
        chk("p1_width", w, 704);

        // Fill with tx disabled: 17th write overflows
        @(negedge clk);
        ifc.tx_en = 1'b0; ifc.parity_en = 1'b0; ifc.parity_type = 1'b0; ifc.tx_thr_val = 2'b11;
        ov_cnt = 0;
        put_seq(8'h00, 17);
        @(negedge clk);
        chk("ov_pulses", ov_cnt, 1);
        chk("ov_low",    ifc.tx_ov, 0);
        chk("full_thr",  ifc.tx_thr, 0);
        chk("full_emp",  ifc.tx_empty, 0);
        ifc.tx_en = 1'b1;
        t_cnt = 0; thr_rise = 0;
        for (int t = 1; t <= 20000; t++) begin
            @(posedge clk); #1;
            if (thr_rise == 0 && ifc.tx_thr === 1'b1) thr_rise = t;
            if (ifc.tx_empty === 1'b1) begin t_cnt = t; break; end
        end
        chk("drain_cycles", t_cnt, 10242);
        chk("thr_rise",     thr_rise, 4482);

        // Three bytes back-to-back; tx_empty one cycle after the last stop bit
        fork put_seq(8'h31, 3); frame_cap(10, bits, w); join
        chk("b2b_bits",   bits[9:0], 10'b1_00110001_0);
        chk("b2b_width",  w, 1920);
        chk("b2b_empty0", ifc.tx_empty, 0);
        @(posedge clk); #1;
        chk("b2b_empty1", ifc.tx_empty, 1);

        // Reset during DATA of 0x55 with 0x66 still queued
        fork
            begin put_seq(8'h55, 1); put_seq(8'h66, 1); end
            frame_cap(1, bits, w);
        join_any
        disable fork;
        repeat (100) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_txd",   ifc.txd, 1);
        chk("mid_rst_busy",  ifc.tx_busy, 0);
        chk("mid_rst_empty", ifc.tx_empty, 1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        busy_cyc = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (ifc.tx_busy !== 1'b0) busy_cyc++;
        end
        chk("post_rst_idle", busy_cyc, 0);

        // tx_en dropped during START of 0x3C; 0x11 waits for re-enable
        fork
            begin put_seq(8'h3C, 1); put_seq(8'h11, 1); end
            frame_cap(10, bits, w);
            begin repeat (12) @(negedge clk); ifc.tx_en = 1'b0; end
        join
        chk("3C_bits",  bits[9:0], 10'b1_00111100_0);
        chk("3C_width", w, 640);
        busy_cyc = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (ifc.tx_busy !== 1'b0) busy_cyc++;
        end
        chk("hold_idle",  busy_cyc, 0);
        chk("hold_empty", ifc.tx_empty, 0);
        @(negedge clk); ifc.tx_en = 1'b1;
        frame_cap(10, bits, w);
        chk("11_bits",  bits[9:0], 10'b1_00010001_0);
        chk("11_width", w, 640);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
